// File: rtl/loopyv_pipe_stage_if.sv
// Handshake bundle for one loopyv pipeline stage: upstream/downstream payload
// handshake plus flush, occupancy and stall statistics.
interface loopyv_pipe_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic                  inValid;
    logic [DATA_WIDTH-1:0] inData;
    logic                  inReady;
    logic                  outValid;
    logic [DATA_WIDTH-1:0] outData;
    logic                  outReady;
    logic                  flush;
    logic [1:0]            occupancy;
    logic [CNT_WIDTH-1:0]  stallCount;
    logic                  statClear;

    modport master (
        output inValid, inData, outReady, flush, statClear,
        input  inReady, outValid, outData, occupancy, stallCount
    );

    modport slave (
        input  inValid, inData, outReady, flush, statClear,
        output inReady, outValid, outData, occupancy, stallCount
    );
endinterface

// File: rtl/loopyv_pipe_stage.sv
// Valid/ready pipeline register with optional skid entry, synchronous flush
// and a saturating downstream back-pressure counter.
module loopyv_pipe_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int SKID_EN    = 1,
    parameter int CNT_WIDTH  = 16
) (
    input logic clk,
    input logic rst_n,
    loopyv_pipe_stage_if.slave bus
);
    typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] main_q, skid_q;
    logic [CNT_WIDTH-1:0]  stall_q;
    logic                  in_ready, out_valid, in_fire, out_fire;
    logic                  load_main, load_skid, main_from_skid;

    // With the skid entry, inReady comes from state alone so outReady never
    // reaches the upstream ready path.
    assign in_ready  = (SKID_EN != 0) ? (state != SKID)
                                      : ((state == EMPTY) || bus.outReady);
    assign out_valid = (state != EMPTY);
    assign in_fire   = bus.inValid && in_ready;
    assign out_fire  = out_valid && bus.outReady;

    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            EMPTY: if (in_fire) begin
                state_nxt = FULL;
                load_main = 1'b1;
            end
            FULL: begin
                if (in_fire && out_fire) begin
                    load_main = 1'b1;
                end else if (in_fire && (SKID_EN != 0)) begin
                    state_nxt = SKID;
                    load_skid = 1'b1;
                end else if (out_fire) begin
                    state_nxt = EMPTY;
                end
            end
            SKID: if (out_fire) begin
                state_nxt      = FULL;
                main_from_skid = 1'b1;
            end
            default: state_nxt = EMPTY;
        endcase
        // Flush kills every entry but leaves the data registers untouched.
        if (bus.flush) begin
            state_nxt      = EMPTY;
            load_main      = 1'b0;
            load_skid      = 1'b0;
            main_from_skid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state <= state_nxt;
            if (load_main)           main_q <= bus.inData;
            else if (main_from_skid) main_q <= skid_q;
            if (load_skid)           skid_q <= bus.inData;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (bus.statClear) begin
            stall_q <= '0;
        end else if (out_valid && !bus.outReady && !bus.flush && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    always_comb begin
        case (state)
            FULL:    bus.occupancy = 2'd1;
            SKID:    bus.occupancy = 2'd2;
            default: bus.occupancy = 2'd0;
        endcase
    end

    assign bus.inReady    = in_ready;
    assign bus.outValid   = out_valid;
    assign bus.outData    = main_q;
    assign bus.stallCount = stall_q;
endmodule

// File: tb/tb_loopyv_pipe_stage.sv
// Bench for loopyv_pipe_stage: skid instance (a) and single-entry 2-bit-counter
// instance (b), directed table, corner sequences and a queue-model random run.
module tb_loopyv_pipe_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    loopyv_pipe_stage_if #(.DATA_WIDTH(32), .CNT_WIDTH(16)) ia ();
    loopyv_pipe_stage_if #(.DATA_WIDTH(32), .CNT_WIDTH(2))  ib ();

    loopyv_pipe_stage #(.DATA_WIDTH(32), .SKID_EN(1), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ia));
    loopyv_pipe_stage #(.DATA_WIDTH(32), .SKID_EN(0), .CNT_WIDTH(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ib));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        fl;
        logic        ov;
        logic [31:0] od;
        logic [1:0]  occ;
        logic        ir;
        logic [15:0] st;
    } vec_t;

    vec_t vt[18];

    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [15:0] sa;
    logic [1:0]  sb;

    task automatic idle_all();
        ia.inValid = 0; ia.inData = '0; ia.outReady = 0; ia.flush = 0; ia.statClear = 0;
        ib.inValid = 0; ib.inData = '0; ib.outReady = 0; ib.flush = 0; ib.statClear = 0;
    endtask

    initial begin
        logic [1:0] exp_st[5];
        bit a_in, a_out, b_in, b_out;

        // inputs | expected outputs of the same cycle, before the edge
        vt[0]  = '{1, 32'h1,  1, 0, 0, 32'h0, 0, 1, 0};
        vt[1]  = '{1, 32'h2,  1, 0, 1, 32'h1, 1, 1, 0};
        vt[2]  = '{1, 32'h3,  1, 0, 1, 32'h2, 1, 1, 0};
        vt[3]  = '{0, 32'h0,  1, 0, 1, 32'h3, 1, 1, 0};
        vt[4]  = '{1, 32'hA,  0, 0, 0, 32'h3, 0, 1, 0};
        vt[5]  = '{1, 32'hB,  0, 0, 1, 32'hA, 1, 1, 0};
        vt[6]  = '{0, 32'h0,  0, 0, 1, 32'hA, 2, 0, 1};
        vt[7]  = '{0, 32'h0,  1, 0, 1, 32'hA, 2, 0, 2};
        vt[8]  = '{0, 32'h0,  1, 0, 1, 32'hB, 1, 1, 2};
        vt[9]  = '{0, 32'h0,  1, 0, 0, 32'hB, 0, 1, 2};
        vt[10] = '{1, 32'hC,  0, 0, 0, 32'hB, 0, 1, 2};
        vt[11] = '{1, 32'hD,  0, 0, 1, 32'hC, 1, 1, 2};
        vt[12] = '{1, 32'hE,  0, 0, 1, 32'hC, 2, 0, 3};
        vt[13] = '{1, 32'hE,  0, 1, 1, 32'hC, 2, 0, 4};
        vt[14] = '{0, 32'h0,  1, 0, 0, 32'hC, 0, 1, 4};
        vt[15] = '{1, 32'hF,  0, 0, 0, 32'hC, 0, 1, 4};
        vt[16] = '{1, 32'h10, 1, 1, 1, 32'hF, 1, 1, 4};
        vt[17] = '{0, 32'h0,  1, 0, 0, 32'hF, 0, 1, 4};
        exp_st = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        idle_all();
        #3;
        chk("rst_a_outValid", ia.outValid, 0);
        chk("rst_a_outData", ia.outData, 0);
        chk("rst_a_occ", ia.occupancy, 0);
        chk("rst_a_inReady", ia.inReady, 1);
        chk("rst_a_stall", ia.stallCount, 0);
        chk("rst_b_inReady", ib.inReady, 1);
        chk("rst_b_outValid", ib.outValid, 0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table on the skid instance
        for (int i = 0; i < 18; i++) begin
            ia.inValid = vt[i].iv; ia.inData = vt[i].d;
            ia.outReady = vt[i].ordy; ia.flush = vt[i].fl;
            @(negedge clk);
            chk($sformatf("vec%0d_outValid", i), ia.outValid, vt[i].ov);
            chk($sformatf("vec%0d_outData", i), ia.outData, vt[i].od);
            chk($sformatf("vec%0d_occ", i), ia.occupancy, vt[i].occ);
            chk($sformatf("vec%0d_inReady", i), ia.inReady, vt[i].ir);
            chk($sformatf("vec%0d_stall", i), ia.stallCount, vt[i].st);
            @(posedge clk); #1;
        end
        idle_all();

        // Single-entry mode: combinational inReady follows outReady
        ib.inValid = 1; ib.inData = 32'h55;
        @(negedge clk);
        chk("b_fill_inReady", ib.inReady, 1);
        @(posedge clk); #1;
        ib.inValid = 0;
        #1 chk("b_full_inReady_low", ib.inReady, 0);
        chk("b_full_outData", ib.outData, 32'h55);
        ib.outReady = 1;
        #1 chk("b_full_inReady_same_cycle", ib.inReady, 1);
        ib.outReady = 0;

        // 2-bit stall counter saturation and clear priority
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("b_stall_%0d", k), ib.stallCount, exp_st[k]);
        end
        ib.statClear = 1;
        @(posedge clk); #1;
        chk("b_stall_clear", ib.stallCount, 0);
        ib.statClear = 0;
        @(posedge clk); #1;
        chk("b_stall_after_clear", ib.stallCount, 1);
        ib.outReady = 1;
        @(posedge clk); #1;
        chk("b_drained", ib.outValid, 0);
        ib.outReady = 0;

        // Asynchronous reset while holding two entries
        ia.inValid = 1; ia.inData = 32'h21;
        @(posedge clk); #1;
        ia.inData = 32'h22;
        @(posedge clk); #1;
        ia.inValid = 0;
        chk("a_pre_rst_occ", ia.occupancy, 2);
        @(posedge clk); #1;
        chk("a_pre_rst_stall_nonzero", ia.stallCount != 0, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_outValid", ia.outValid, 0);
        chk("async_rst_occ", ia.occupancy, 0);
        chk("async_rst_stall", ia.stallCount, 0);
        chk("async_rst_outData", ia.outData, 0);
        chk("async_rst_inReady", ia.inReady, 1);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Random traffic on both instances against FIFO queue models
        qa.delete(); qb.delete(); sa = 0; sb = 0;
        for (int c = 0; c < 400; c++) begin
            ia.inValid = ($urandom % 4) != 0; ia.inData = $urandom;
            ia.outReady = ($urandom % 3) != 0; ia.flush = ($urandom % 16) == 0;
            ia.statClear = ($urandom % 40) == 0;
            ib.inValid = ($urandom % 4) != 0; ib.inData = $urandom;
            ib.outReady = ($urandom % 3) != 0; ib.flush = ($urandom % 16) == 0;
            ib.statClear = ($urandom % 40) == 0;
            @(negedge clk);
            chk("rnd_a_outValid", ia.outValid, qa.size() > 0);
            chk("rnd_a_inReady", ia.inReady, qa.size() < 2);
            chk("rnd_a_occ", ia.occupancy, qa.size());
            chk("rnd_a_stall", ia.stallCount, sa);
            if (qa.size() > 0) chk("rnd_a_outData", ia.outData, qa[0]);
            chk("rnd_b_outValid", ib.outValid, qb.size() > 0);
            chk("rnd_b_inReady", ib.inReady, (qb.size() == 0) || ib.outReady);
            chk("rnd_b_occ", ib.occupancy, qb.size());
            chk("rnd_b_stall", ib.stallCount, sb);
            if (qb.size() > 0) chk("rnd_b_outData", ib.outData, qb[0]);
            a_in  = ia.inValid && (qa.size() < 2);
            a_out = (qa.size() > 0) && ia.outReady;
            b_in  = ib.inValid && ((qb.size() == 0) || ib.outReady);
            b_out = (qb.size() > 0) && ib.outReady;
            @(posedge clk);
            if (ia.statClear) sa = 0;
            else if (qa.size() > 0 && !ia.outReady && !ia.flush && sa != 16'hFFFF) sa++;
            if (ia.flush) qa.delete();
            else begin
                if (a_out) void'(qa.pop_front());
                if (a_in) qa.push_back(ia.inData);
            end
            if (ib.statClear) sb = 0;
            else if (qb.size() > 0 && !ib.outReady && !ib.flush && sb != 2'd3) sb++;
            if (ib.flush) qb.delete();
            else begin
                if (b_out) void'(qb.pop_front());
                if (b_in) qb.push_back(ib.inData);
            end
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
